// File: rtl/sevenseg_scan_ctrl_if.sv
// ----------------------------------------------------------------------------
// sevenseg_scan_ctrl_if
//   Bundle between a host that supplies display content and the
//   eight-digit seven-segment scan controller.
//
//   data_in  [55:0]  eight 7-bit digit codes, digit i at [7i+6:7i]
//   digit_en [7:0]   per-digit enables, bit i lights digit i
//   load             request capture of data_in / digit_en
//   busy             a captured update is waiting for the next frame boundary
//   ack              one-cycle pulse when the pending update becomes active
//   frame            one-cycle pulse on the first cycle of digit 0 after 7
//   code     [6:0]   active code of the digit currently being scanned
//   an_n     [7:0]   active-low anode drive, one-hot-low or all ones
//
//   master : host side (drives content, observes status/display)
//   slave  : controller side
// ----------------------------------------------------------------------------
interface sevenseg_scan_ctrl_if;
   logic [55:0] data_in;
   logic [7:0]  digit_en;
   logic        load;
   logic        busy;
   logic        ack;
   logic        frame;
   logic [6:0]  code;
   logic [7:0]  an_n;

   modport master (
      output data_in, digit_en, load,
      input  busy, ack, frame, code, an_n
   );

   modport slave (
      input  data_in, digit_en, load,
      output busy, ack, frame, code, an_n
   );
endinterface

// File: rtl/sevenseg_scan_ctrl.sv
// ----------------------------------------------------------------------------
// sevenseg_scan_ctrl
//   Time-multiplexed scan controller for an eight-digit seven-segment
//   display. Each digit owns a slot of DIV clock cycles; the last BLANK_CYC
//   cycles of every slot switch all anodes off to suppress ghosting.
//   New content is double-buffered: a load is captured into pending
//   registers and only copied into the active registers at a frame boundary
//   (slot wrap with digit 7), so a frame never mixes old and new content.
//
// Parameters
//   DIV        clock cycles per digit slot (>= 2)
//   BLANK_CYC  blanking cycles at the end of each slot (0 <= BLANK_CYC < DIV)
//
// Ports
//   clk   system clock, rising edge
//   rst   synchronous active-high reset
//   bus   sevenseg_scan_ctrl_if.slave (data_in, digit_en, load in;
//         busy, ack, frame, code, an_n out)
// ----------------------------------------------------------------------------
module sevenseg_scan_ctrl #(
   parameter int DIV       = 100000,
   parameter int BLANK_CYC = 1000
) (
   input  logic                 clk,
   input  logic                 rst,
   sevenseg_scan_ctrl_if.slave  bus
);

   localparam int CNT_W = $clog2(DIV);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
   // One extra bit: DIV - BLANK_CYC may equal DIV, which can overflow CNT_W.
   localparam logic [CNT_W:0]   SHOW_LEN = (CNT_W + 1)'(DIV - BLANK_CYC);

   if (DIV < 2) begin : g_bad_div
      $error("sevenseg_scan_ctrl: DIV must be >= 2");
   end
   if ((BLANK_CYC < 0) || (BLANK_CYC >= DIV)) begin : g_bad_blank
      $error("sevenseg_scan_ctrl: BLANK_CYC must satisfy 0 <= BLANK_CYC < DIV");
   end

   typedef enum logic {
      SHOW  = 1'b0,
      BLANK = 1'b1
   } state_t;

   state_t            state;
   state_t            state_nxt;

   logic [CNT_W-1:0]  cnt;
   logic [CNT_W-1:0]  cnt_nxt;
   logic [2:0]        idx;
   logic [2:0]        idx_nxt;
   logic              slot_end;
   logic              frame_end;

   logic [55:0]       pend_data;
   logic [7:0]        pend_en;
   logic [55:0]       act_data;
   logic [7:0]        act_en;
   logic              busy;
   logic              ack;
   logic              frame;
   logic              load_take;
   logic              apply;

   logic [7:0]        an_n_c;

   // Select the 7-bit code of digit i from a packed 8-digit word.
   function automatic logic [6:0] digit_code(input logic [55:0] d, input logic [2:0] i);
      logic [6:0] r;
      r = '0;
      for (int k = 0; k < 8; k++) begin
         if (i == 3'(k)) begin
            r = d[7*k +: 7];
         end
      end
      return r;
   endfunction

   // ------------------------------------------------------------------------
   // Slot / digit sequencing
   // ------------------------------------------------------------------------
   always_comb begin
      slot_end  = (cnt == CNT_LAST);
      frame_end = slot_end && (idx == 3'd7);
      cnt_nxt   = slot_end ? '0 : cnt + 1'b1;
      // 3-bit index wraps 7 -> 0 by itself.
      idx_nxt   = slot_end ? idx + 3'd1 : idx;
      // Only a free slot can accept a load; a busy one ignores it.
      load_take = bus.load && !busy;
      apply     = frame_end && busy;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
         idx <= '0;
      end else begin
         cnt <= cnt_nxt;
         idx <= idx_nxt;
      end
   end

   // ------------------------------------------------------------------------
   // SHOW/BLANK state: registered, so the decoded value must be taken from
   // the counter value it will hold in the next cycle.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= SHOW;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = SHOW;
      an_n_c    = 8'hFF;
      if ({1'b0, cnt_nxt} >= SHOW_LEN) begin
         state_nxt = BLANK;
      end
      // Anode decode straight from registered state: no extra latency.
      if ((state == SHOW) && act_en[idx]) begin
         an_n_c[idx] = 1'b0;
      end
   end

   // ------------------------------------------------------------------------
   // Double-buffered content and handshake
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         pend_data <= '0;
         pend_en   <= '0;
         act_data  <= '0;
         act_en    <= '0;
         busy      <= 1'b0;
         ack       <= 1'b0;
         frame     <= 1'b0;
      end else begin
         // frame and ack are registered so they coincide with the first
         // cycle of digit 0 in the new frame.
         frame <= frame_end;
         ack   <= apply;
         if (apply) begin
            act_data <= pend_data;
            act_en   <= pend_en;
         end
         // A load taken in a boundary cycle with busy=0 is not applied
         // now: apply only looks at the old busy value.
         if (load_take) begin
            pend_data <= bus.data_in;
            pend_en   <= bus.digit_en;
         end
         busy <= (busy && !frame_end) || load_take;
      end
   end

   assign bus.busy  = busy;
   assign bus.ack   = ack;
   assign bus.frame = frame;
   assign bus.code  = digit_code(act_data, idx);
   assign bus.an_n  = an_n_c;

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// ----------------------------------------------------------------------------
// tb_sevenseg_scan_ctrl
//   Two controllers (BLANK_CYC=1 and BLANK_CYC=0, DIV=4) receive identical
//   stimulus. A reference model based on elapsed-cycle arithmetic predicts
//   every cycle's outputs; the driver pushes predictions into a queue and an
//   independent monitor pops and compares them on the falling edge.
// ----------------------------------------------------------------------------
module tb_sevenseg_scan_ctrl;
   localparam int DIV   = 4;
   localparam int BLANK = 1;
   localparam int FRAME = 8 * DIV;

   typedef struct packed {
      logic [7:0] an_n;
      logic [7:0] an_n0;
      logic [6:0] code;
      logic       busy;
      logic       ack;
      logic       frame;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [55:0] din;
   logic [7:0]  den;
   logic        ld;

   int checks = 0;
   int errors = 0;

   exp_t exp_q[$];

   always #5 clk = ~clk;

   sevenseg_scan_ctrl_if bus1();
   sevenseg_scan_ctrl_if bus0();

   assign bus1.data_in  = din;
   assign bus1.digit_en = den;
   assign bus1.load     = ld;
   assign bus0.data_in  = din;
   assign bus0.digit_en = den;
   assign bus0.load     = ld;

   sevenseg_scan_ctrl #(.DIV(DIV), .BLANK_CYC(BLANK)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus1)
   );

   sevenseg_scan_ctrl #(.DIV(DIV), .BLANK_CYC(0)) dut0 (
      .clk (clk),
      .rst (rst),
      .bus (bus0)
   );

   // Reference model: time since reset release plus the two content copies.
   int          m_t;
   logic        m_busy;
   logic        m_ack;
   logic [55:0] m_pend;
   logic [7:0]  m_pen;
   logic [55:0] m_act;
   logic [7:0]  m_aen;

   function automatic exp_t expect_now();
      exp_t e;
      int   digit;
      int   pos;
      digit   = (m_t / DIV) % 8;
      pos     = m_t % DIV;
      e.an_n  = ((pos < DIV - BLANK) && m_aen[digit]) ? ~(8'd1 << digit) : 8'hFF;
      e.an_n0 = m_aen[digit] ? ~(8'd1 << digit) : 8'hFF;
      e.code  = m_act[digit*7 +: 7];
      e.busy  = m_busy;
      e.ack   = m_ack;
      e.frame = (m_t > 0) && ((m_t % FRAME) == 0);
      return e;
   endfunction

   task automatic model_reset();
      m_t    = 0;
      m_busy = 1'b0;
      m_ack  = 1'b0;
      m_pend = '0;
      m_pen  = '0;
      m_act  = '0;
      m_aen  = '0;
   endtask

   task automatic model_edge(input logic l, input logic [55:0] d, input logic [7:0] e, input logic r);
      logic boundary;
      logic old_busy;
      if (r) begin
         model_reset();
      end else begin
         boundary = ((m_t + 1) % FRAME) == 0;
         old_busy = m_busy;
         m_ack    = boundary && old_busy;
         if (boundary && old_busy) begin
            m_act  = m_pend;
            m_aen  = m_pen;
            m_busy = 1'b0;
         end
         if (l && !old_busy) begin
            m_pend = d;
            m_pen  = e;
            m_busy = 1'b1;
         end
         m_t = m_t + 1;
      end
   endtask

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s t=%0t actual=%02h required=%02h", nm, $time, act, req);
      end
   endtask

   // Called just after a rising edge: records the prediction for the cycle
   // now starting, applies its inputs and advances the model over the edge.
   task automatic step(input logic l, input logic [55:0] d, input logic [7:0] e, input logic r);
      exp_q.push_back(expect_now());
      ld  = l;
      din = d;
      den = e;
      rst = r;
      @(posedge clk);
      #1;
      model_edge(l, d, e, r);
   endtask

   task automatic idle();
      step(1'b0, 56'd0, 8'd0, 1'b0);
   endtask

   task automatic idle_until(input int phase, input logic want_busy, input string nm);
      int n;
      n = 0;
      while (!(((m_t % FRAME) == phase) && (m_busy == want_busy)) && (n < 200)) begin
         idle();
         n++;
      end
      checks++;
      if (n >= 200) begin
         errors++;
         $display("FAIL %s wait expired actual=%0d cycles required<200", nm, n);
      end
   endtask

   function automatic logic [55:0] rand56();
      logic [63:0] t;
      t = {$urandom(), $urandom()};
      return t[55:0];
   endfunction

   // Monitor: pops one prediction per cycle and compares both DUTs.
   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("an_n",    bus1.an_n,            e.an_n);
         chk("code",    {1'b0, bus1.code},    {1'b0, e.code});
         chk("busy",    {7'd0, bus1.busy},    {7'd0, e.busy});
         chk("ack",     {7'd0, bus1.ack},     {7'd0, e.ack});
         chk("frame",   {7'd0, bus1.frame},   {7'd0, e.frame});
         chk("an_n_b0", bus0.an_n,            e.an_n0);
         chk("code_b0", {1'b0, bus0.code},    {1'b0, e.code});
         chk("busy_b0", {7'd0, bus0.busy},    {7'd0, e.busy});
         chk("ack_b0",  {7'd0, bus0.ack},     {7'd0, e.ack});
         chk("frame_b0",{7'd0, bus0.frame},   {7'd0, e.frame});
      end
   end

   initial begin
      logic [55:0] d_inc;
      logic [55:0] d_other;
      logic        l;
      logic        r;

      for (int k = 0; k < 8; k++) begin
         d_inc[7*k +: 7]   = 7'(k + 1);
         d_other[7*k +: 7] = 7'(7'h70 - k);
      end

      rst = 1'b1;
      ld  = 1'b0;
      din = '0;
      den = '0;
      repeat (2) @(posedge clk);
      #1;
      model_reset();

      // Held reset with a load present: outputs stay at reset values.
      step(1'b1, d_inc, 8'hFF, 1'b1);

      // Idle two frames: frames every 32 cycles, anodes off.
      repeat (64) idle();

      // Load, then a second load while busy that must be ignored.
      step(1'b1, d_inc, 8'hFF, 1'b0);
      step(1'b1, d_other, 8'hAA, 1'b0);
      repeat (80) idle();

      // Upper four digits disabled.
      step(1'b1, rand56(), 8'h0F, 1'b0);
      repeat (70) idle();

      // Load in the boundary cycle itself with busy=0: applied one frame later.
      idle_until(FRAME - 1, 1'b0, "wait_boundary");
      step(1'b1, rand56(), 8'hFF, 1'b0);
      repeat (70) idle();

      // Reset during digit 5 SHOW with an update pending.
      idle_until(1, 1'b0, "wait_after_boundary");
      step(1'b1, d_other, 8'hFF, 1'b0);
      idle_until(5 * DIV + 1, 1'b1, "wait_digit5");
      step(1'b0, 56'd0, 8'd0, 1'b1);
      repeat (70) idle();

      // Randomized traffic with occasional resets.
      repeat (1500) begin
         l = ($urandom_range(0, 9) == 0);
         r = ($urandom_range(0, 299) == 0);
         step(l, rand56(), 8'($urandom()), r);
      end

      repeat (2) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL queue_drain actual=%0d required=0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
